run_length_extractor: RTL and testbench

// - Upstream stage of the run-length histogram: slices a FRAME_BITS-bit serial frame into runs of equal bits.
// - Emits one event {run_val, run_len} per run through a small output FIFO with a valid/ready handshake.
// - Runs longer than MAX_RUN are split into MAX_RUN-sized events.
// - The histogram stage consumes run_len directly, with bin = run_len-1.

---
 rtl/hist_pkg.sv | 15 +
 rtl/run_evt_fifo.sv | 48 ++++
 rtl/run_length_extractor.sv | 150 +++++++++++++++
 tb/tb_run_length_extractor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared types and defaults for the run-length histogram front end.
package hist_pkg;

    localparam int unsigned FRAME_BITS_DEF = 1024;
    localparam int unsigned MAX_RUN_DEF    = 16;
    localparam int unsigned LW             = $clog2(MAX_RUN_DEF) + 1;

    typedef struct packed {
        logic          val;
        logic [LW-1:0] len;
    } run_evt_t;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} rle_state_t;

endpackage

// File: rtl/run_evt_fifo.sv
// Synchronous first-word-fall-through FIFO of run events with synchronous clear.
module run_evt_fifo
    import hist_pkg::*;
#(
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     push,
    input  run_evt_t wdata,
    input  logic     pop,
    output run_evt_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(OUT_DEPTH);

    logic [AW:0] wptr_q, rptr_q;
    run_evt_t    mem_q [OUT_DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot being written, so a push while full still lands.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/run_length_extractor.sv
// Slices a serial frame into equal-bit runs (split at MAX_RUN) and queues {val, len} events.
module run_length_extractor
    import hist_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
    parameter int unsigned MAX_RUN    = MAX_RUN_DEF,
    parameter int unsigned OUT_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hist_init,
    input  logic          data_valid,
    input  logic          data_in,
    output logic          run_valid,
    input  logic          run_ready,
    output logic          run_val,
    output logic [LW-1:0] run_len,
    output logic          frame_done,
    output logic          frame_short,
    output logic          overflow
);

    localparam int unsigned BW = $clog2(FRAME_BITS);

    rle_state_t    state_q;
    logic          cur_val_q;
    logic [LW-1:0] run_cnt_q;
    logic [BW-1:0] bit_cnt_q;
    logic          push_q;
    run_evt_t      evt_q;
    logic          frame_done_q, frame_short_q, overflow_q;

    run_evt_t      head;
    logic          fifo_full, fifo_empty;
    logic          last_bit, run_brk;

    assign last_bit = (bit_cnt_q == BW'(FRAME_BITS - 1));
    assign run_brk  = (data_in != cur_val_q) || (run_cnt_q == LW'(MAX_RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_val_q     <= 1'b0;
            run_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            push_q        <= 1'b0;
            evt_q         <= '0;
            frame_done_q  <= 1'b0;
            frame_short_q <= 1'b0;
        end else if (hist_init) begin
            state_q       <= IDLE;
            cur_val_q     <= 1'b0;
            run_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            push_q        <= 1'b0;
            evt_q         <= '0;
            frame_done_q  <= 1'b0;
            frame_short_q <= 1'b0;
        end else begin
            push_q       <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_valid) begin
                        cur_val_q <= data_in;
                        run_cnt_q <= LW'(1);
                        bit_cnt_q <= BW'(1);
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (!data_valid) begin
                        push_q        <= 1'b1;
                        evt_q         <= {cur_val_q, run_cnt_q};
                        frame_short_q <= 1'b1;
                        run_cnt_q     <= '0;
                        bit_cnt_q     <= '0;
                        state_q       <= IDLE;
                    end else if (run_brk) begin
                        push_q    <= 1'b1;
                        evt_q     <= {cur_val_q, run_cnt_q};
                        cur_val_q <= data_in;
                        run_cnt_q <= LW'(1);
                        // On the last bit the fresh {data_in, 1} run waits in FLUSH.
                        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
                        state_q   <= last_bit ? FLUSH : RUN;
                    end else if (last_bit) begin
                        push_q       <= 1'b1;
                        evt_q        <= {cur_val_q, run_cnt_q + 1'b1};
                        frame_done_q <= 1'b1;
                        run_cnt_q    <= '0;
                        bit_cnt_q    <= '0;
                        state_q      <= IDLE;
                    end else begin
                        run_cnt_q <= run_cnt_q + 1'b1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                FLUSH: begin
                    push_q       <= 1'b1;
                    evt_q        <= {cur_val_q, run_cnt_q};
                    frame_done_q <= 1'b1;
                    if (data_valid) begin
                        cur_val_q <= data_in;
                        run_cnt_q <= LW'(1);
                        bit_cnt_q <= BW'(1);
                        state_q   <= RUN;
                    end else begin
                        run_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (hist_init) begin
            overflow_q <= 1'b0;
        end else if (push_q && fifo_full && !run_ready) begin
            overflow_q <= 1'b1;
        end
    end

    run_evt_fifo #(
        .OUT_DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hist_init),
        .push  (push_q),
        .wdata (evt_q),
        .pop   (run_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign run_valid   = !fifo_empty;
    assign run_val     = head.val;
    assign run_len     = head.len;
    assign frame_done  = frame_done_q;
    assign frame_short = frame_short_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_run_length_extractor.sv
// Directed self-checking bench for run_length_extractor.
module tb_run_length_extractor;
    import hist_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hist_init;
    logic          data_valid;
    logic          data_in;
    logic          run_valid;
    logic          run_ready;
    logic          run_val;
    logic [LW-1:0] run_len;
    logic          frame_done;
    logic          frame_short;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    logic [LW:0] got_q[$];
    logic [LW:0] exp_q[$];
    int          done_cnt;
    int          done_at;

    run_length_extractor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hist_init   (hist_init),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .run_valid   (run_valid),
        .run_ready   (run_ready),
        .run_val     (run_val),
        .run_len     (run_len),
        .frame_done  (frame_done),
        .frame_short (frame_short),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Record each head the consumer accepts, and where frame_done lands in that stream.
    always @(negedge clk) begin
        if (rst_n && run_valid && run_ready) got_q.push_back({run_val, run_len});
        if (rst_n && frame_done) begin
            done_cnt++;
            done_at = got_q.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pat 0: 1010..., pat 1: all ones, pat 2: zeros with a final 1.
    function automatic logic pat_bit(input int pat, input int i, input int n);
        case (pat)
            0:       return (i % 2 == 0);
            1:       return 1'b1;
            default: return (i == n - 1);
        endcase
    endfunction

    task automatic run_frame(input int pat, input int n, input logic ready);
        got_q.delete();
        done_cnt  = 0;
        done_at   = -1;
        run_ready = ready;
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b1;
            data_in    = pat_bit(pat, i, n);
            tick();
        end
        data_valid = 1'b0;
        data_in    = 1'b0;
        repeat (12) tick();
    endtask

    task automatic compare_events(input string tag);
        check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_evt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        rst_n      = 1'b0;
        hist_init  = 1'b0;
        data_valid = 1'b0;
        data_in    = 1'b0;
        run_ready  = 1'b0;
        done_cnt   = 0;
        done_at    = -1;
        repeat (3) tick();
        check("rst_run_valid", 32'(run_valid), 0);
        check("rst_run_val", 32'(run_val), 0);
        check("rst_run_len", 32'(run_len), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_short", 32'(frame_short), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // Alternating bits: 1024 single-bit runs.
        run_frame(0, 1024, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) exp_q.push_back({(i % 2 == 0) ? 1'b1 : 1'b0, LW'(1)});
        compare_events("alt");
        check("alt_done_cnt", done_cnt, 1);
        check("alt_done_at", done_at, 1023);
        check("alt_short", 32'(frame_short), 0);
        check("alt_overflow", 32'(overflow), 0);

        // All ones: 64 max-length runs, last pushed with frame_done.
        run_frame(1, 1024, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back({1'b1, LW'(16)});
        compare_events("ones");
        check("ones_done_cnt", done_cnt, 1);
        check("ones_done_at", done_at, 63);

        // 1023 zeros then a 1: the trailing {1,1} goes out via FLUSH.
        run_frame(2, 1024, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 63; i++) exp_q.push_back({1'b0, LW'(16)});
        exp_q.push_back({1'b0, LW'(15)});
        exp_q.push_back({1'b1, LW'(1)});
        compare_events("zeros");
        check("zeros_done_cnt", done_cnt, 1);
        check("zeros_done_at", done_at, 64);
        check("zeros_short", 32'(frame_short), 0);

        // Early end after 40 ones.
        run_frame(1, 40, 1'b1);
        exp_q.delete();
        exp_q.push_back({1'b1, LW'(16)});
        exp_q.push_back({1'b1, LW'(16)});
        exp_q.push_back({1'b1, LW'(8)});
        compare_events("early");
        check("early_short", 32'(frame_short), 1);
        check("early_done_cnt", done_cnt, 0);

        hist_init = 1'b1;
        tick();
        hist_init = 1'b0;
        check("init_short", 32'(frame_short), 0);

        // Stalled consumer: FIFO fills with four events, later pushes overflow.
        run_frame(0, 8, 1'b0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_valid", 32'(run_valid), 1);
        check("ovf_head_val", 32'(run_val), 1);
        check("ovf_head_len", 32'(run_len), 1);
        run_ready = 1'b1;
        tick();
        run_ready = 1'b0;
        check("ovf_next_val", 32'(run_val), 0);
        check("ovf_next_len", 32'(run_len), 1);
        check("ovf_next_valid", 32'(run_valid), 1);
        hist_init = 1'b1;
        tick();
        hist_init = 1'b0;
        check("init_valid", 32'(run_valid), 0);
        check("init_overflow", 32'(overflow), 0);
        check("init_short2", 32'(frame_short), 0);

        // Async reset mid-frame with events queued.
        run_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data_valid = 1'b1;
            data_in    = 1'b1;
            tick();
        end
        check("pre_rst_valid", 32'(run_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(run_valid), 0);
        check("mid_rst_len", 32'(run_len), 0);
        check("mid_rst_done", 32'(frame_done), 0);
        check("mid_rst_short", 32'(frame_short), 0);
        check("mid_rst_overflow", 32'(overflow), 0);
        data_valid = 1'b0;
        data_in    = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_frame(1, 1024, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back({1'b1, LW'(16)});
        compare_events("post_rst");
        check("post_rst_done_cnt", done_cnt, 1);
        check("post_rst_done_at", done_at, 63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
